// File: rtl/k_fetch_ctrl.sv
// k_fetch_ctrl: initiator side of the K-constant interface.
// Walks K-ROM addresses 0..K_LENGTH-1, reads each word from a synchronous
// memory with MEM_LATENCY cycles of read latency and presents it to the
// round-constant consumer as k_data/k_address/k_valid, advancing one word per
// next_req pulse. address_read_complete is raised once the last word has
// been consumed.
//
// Optional build macro: K_FETCH_PREFETCH_EN
//   When defined, a one-word prefetch buffer reads word a+1 as soon as word a
//   is presented, so a consumer that is slower than the memory never sees a
//   k_valid bubble between words.
//
// State table:
//   state | meaning
//   IDLE  | not running, all outputs low
//   ISSUE | read strobe for addr is on the memory port this cycle
//   WAIT  | counting down the memory latency for the word at addr
//   HOLD  | word addr presented with k_valid=1, waiting for next_req
//   DONE  | last word consumed, address_read_complete held high
module k_fetch_ctrl #(
  parameter int K_LENGTH    = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        next_req,
  output logic                        mem_read_en,
  output logic [$clog2(K_LENGTH)-1:0] mem_address,
  input  logic [31:0]                 mem_data,
  output logic                        k_valid,
  output logic [$clog2(K_LENGTH)-1:0] k_address,
  output logic [31:0]                 k_data,
  output logic                        address_read_complete,
  output logic                        busy
);

  localparam int AW = $clog2(K_LENGTH);
  localparam logic [AW-1:0] LAST = AW'(K_LENGTH - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);
  // Latency counter is loaded on the cycle the strobe becomes visible and
  // reaches zero on the cycle the data is on mem_data.
  localparam logic [2:0]    LAT  = 3'(MEM_LATENCY);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr, addr_nxt;
  logic [2:0]      lat_cnt, lat_cnt_nxt;
  logic            rd_en_nxt;
  logic [AW-1:0]   rd_addr_nxt;
  logic            valid_nxt;
  logic [AW-1:0]   kaddr_nxt;
  logic [31:0]     kdata_nxt;
  logic            done_nxt;

`ifdef K_FETCH_PREFETCH_EN
  logic            pf_pending, pf_pending_nxt;
  logic            pf_full, pf_full_nxt;
  logic [31:0]     pf_data, pf_data_nxt;
`endif

  // State, counters and all registered outputs; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= IDLE;
      addr                  <= '0;
      lat_cnt               <= '0;
      mem_read_en           <= 1'b0;
      mem_address           <= '0;
      k_valid               <= 1'b0;
      k_address             <= '0;
      k_data                <= '0;
      address_read_complete <= 1'b0;
`ifdef K_FETCH_PREFETCH_EN
      pf_pending            <= 1'b0;
      pf_full               <= 1'b0;
      pf_data               <= '0;
`endif
    end else begin
      state                 <= state_nxt;
      addr                  <= addr_nxt;
      lat_cnt               <= lat_cnt_nxt;
      mem_read_en           <= rd_en_nxt;
      mem_address           <= rd_addr_nxt;
      k_valid               <= valid_nxt;
      k_address             <= kaddr_nxt;
      k_data                <= kdata_nxt;
      address_read_complete <= done_nxt;
`ifdef K_FETCH_PREFETCH_EN
      pf_pending            <= pf_pending_nxt;
      pf_full               <= pf_full_nxt;
      pf_data               <= pf_data_nxt;
`endif
    end
  end

  // Next-state and next-output logic; enable low overrides every state.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    lat_cnt_nxt = lat_cnt;
    rd_en_nxt   = 1'b0;
    rd_addr_nxt = mem_address;
    valid_nxt   = k_valid;
    kaddr_nxt   = k_address;
    kdata_nxt   = k_data;
    done_nxt    = address_read_complete;
`ifdef K_FETCH_PREFETCH_EN
    pf_pending_nxt = pf_pending;
    pf_full_nxt    = pf_full;
    pf_data_nxt    = pf_data;
`endif

    if (!enable) begin
      // Abort: in-flight memory data is simply never captured.
      state_nxt   = IDLE;
      addr_nxt    = '0;
      lat_cnt_nxt = '0;
      rd_addr_nxt = '0;
      valid_nxt   = 1'b0;
      kaddr_nxt   = '0;
      kdata_nxt   = '0;
      done_nxt    = 1'b0;
`ifdef K_FETCH_PREFETCH_EN
      pf_pending_nxt = 1'b0;
      pf_full_nxt    = 1'b0;
      pf_data_nxt    = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = ISSUE;
          addr_nxt    = '0;
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = '0;
          lat_cnt_nxt = LAT;
        end

        ISSUE: begin
          state_nxt   = WAIT;
          lat_cnt_nxt = lat_cnt - 3'd1;
        end

        WAIT: begin
          if (lat_cnt == 3'd0) begin
            state_nxt = HOLD;
            valid_nxt = 1'b1;
            kaddr_nxt = addr;
            kdata_nxt = mem_data;
`ifdef K_FETCH_PREFETCH_EN
            pf_pending_nxt = 1'b0;
            pf_full_nxt    = 1'b0;
            if (addr != LAST) begin
              rd_en_nxt      = 1'b1;
              rd_addr_nxt    = addr + ONE;
              lat_cnt_nxt    = LAT;
              pf_pending_nxt = 1'b1;
            end
`endif
          end else begin
            lat_cnt_nxt = lat_cnt - 3'd1;
          end
        end

        HOLD: begin
`ifdef K_FETCH_PREFETCH_EN
          // Background fill of the prefetch buffer.
          if (pf_pending) begin
            if (lat_cnt == 3'd0) begin
              pf_data_nxt    = mem_data;
              pf_full_nxt    = 1'b1;
              pf_pending_nxt = 1'b0;
            end else begin
              lat_cnt_nxt = lat_cnt - 3'd1;
            end
          end
          if (next_req) begin
            if (addr == LAST) begin
              state_nxt = DONE;
              valid_nxt = 1'b0;
              done_nxt  = 1'b1;
            end else if (pf_full || (pf_pending && lat_cnt == 3'd0)) begin
              // Next word is already here (or arriving now): no bubble.
              addr_nxt       = addr + ONE;
              kaddr_nxt      = addr + ONE;
              kdata_nxt      = pf_full ? pf_data : mem_data;
              pf_full_nxt    = 1'b0;
              pf_pending_nxt = 1'b0;
              if ((addr + ONE) != LAST) begin
                rd_en_nxt      = 1'b1;
                rd_addr_nxt    = addr + AW'(2);
                lat_cnt_nxt    = LAT;
                pf_pending_nxt = 1'b1;
              end
            end else begin
              // Prefetch still in flight: wait for it without re-issuing.
              state_nxt = WAIT;
              addr_nxt  = addr + ONE;
              valid_nxt = 1'b0;
            end
          end
`else
          if (next_req) begin
            valid_nxt = 1'b0;
            if (addr == LAST) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt   = ISSUE;
              addr_nxt    = addr + ONE;
              rd_en_nxt   = 1'b1;
              rd_addr_nxt = addr + ONE;
              lat_cnt_nxt = LAT;
            end
          end
`endif
        end

        DONE: begin
          state_nxt = DONE;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_k_fetch_ctrl.sv
// Directed bench for k_fetch_ctrl: one instance at MEM_LATENCY=1 and one at
// MEM_LATENCY=3, each driven from a small synchronous ROM model.
module tb_k_fetch_ctrl;

  localparam int KL = 64;
  localparam int AW = 6;

  logic          clock = 1'b0;
  logic          reset, enable, next_req, enable3, next_req3;
  logic          mem_read_en, k_valid, address_read_complete, busy;
  logic [AW-1:0] mem_address, k_address;
  logic [31:0]   mem_data, k_data;
  logic          mem_read_en3, k_valid3, address_read_complete3, busy3;
  logic [AW-1:0] mem_address3, k_address3;
  logic [31:0]   mem_data3, k_data3;

  int vectors = 0;
  int miscompares = 0;
  int rd_cnt = 0;

  always #5 clock = ~clock;

  k_fetch_ctrl #(.K_LENGTH(KL), .MEM_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .enable(enable), .next_req(next_req),
    .mem_read_en(mem_read_en), .mem_address(mem_address), .mem_data(mem_data),
    .k_valid(k_valid), .k_address(k_address), .k_data(k_data),
    .address_read_complete(address_read_complete), .busy(busy)
  );

  k_fetch_ctrl #(.K_LENGTH(KL), .MEM_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .enable(enable3), .next_req(next_req3),
    .mem_read_en(mem_read_en3), .mem_address(mem_address3), .mem_data(mem_data3),
    .k_valid(k_valid3), .k_address(k_address3), .k_data(k_data3),
    .address_read_complete(address_read_complete3), .busy(busy3)
  );

  function automatic logic [31:0] rom(input int i);
    if (i == 0)  return 32'h428a2f98;
    if (i == 63) return 32'hc67178f2;
    return (32'h9e3779b9 * 32'(i + 1)) ^ 32'(i << 8);
  endfunction

  // ROM models: data valid exactly latency cycles after the strobe, garbage otherwise.
  logic [31:0] m1;
  logic [31:0] m3 [3];
  always @(posedge clock) begin
    m1    <= mem_read_en ? rom(int'(mem_address)) : 32'hdeadbeef;
    m3[0] <= mem_read_en3 ? rom(int'(mem_address3)) : 32'hdeadbeef;
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign mem_data  = m1;
  assign mem_data3 = m3[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (mem_read_en) rd_cnt++;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_rd"},    32'(mem_read_en), 0);
    check({tag, "_maddr"}, 32'(mem_address), 0);
    check({tag, "_valid"}, 32'(k_valid), 0);
    check({tag, "_kaddr"}, 32'(k_address), 0);
    check({tag, "_kdata"}, k_data, 0);
    check({tag, "_cmpl"},  32'(address_read_complete), 0);
    check({tag, "_busy"},  32'(busy), 0);
  endtask

  // Pulse next_req on every valid cycle until n words are consumed.
  task automatic sweep(input string tag, input int n);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 2000) begin
      if (k_valid) begin
        check({tag, "_kaddr"}, 32'(k_address), 32'(idx));
        check({tag, "_kdata"}, k_data, rom(idx));
        next_req = 1'b1;
        idx++;
      end else begin
        next_req = 1'b0;
      end
      tick();
      cyc++;
    end
    next_req = 1'b0;
    check({tag, "_words"}, 32'(idx), 32'(n));
  endtask

  // Restart from IDLE and check the first-word timing.
  task automatic start_check(input string tag);
    enable = 1'b1;
    tick();
    check({tag, "_c1_rd"},    32'(mem_read_en), 1);
    check({tag, "_c1_maddr"}, 32'(mem_address), 0);
    check({tag, "_c1_busy"},  32'(busy), 1);
    check({tag, "_c1_valid"}, 32'(k_valid), 0);
    tick();
    check({tag, "_c2_rd"},    32'(mem_read_en), 0);
    check({tag, "_c2_valid"}, 32'(k_valid), 0);
    tick();
    check({tag, "_c3_valid"}, 32'(k_valid), 1);
    check({tag, "_c3_kaddr"}, 32'(k_address), 0);
    check({tag, "_c3_kdata"}, k_data, 32'h428a2f98);
  endtask

  initial begin
    int exp_idx;
    int cyc;
    int rd_cyc;
    logic prev_v;

    reset = 1'b1; enable = 1'b0; next_req = 1'b0;
    enable3 = 1'b0; next_req3 = 1'b0;
    repeat (3) tick();
    expect_idle("rst");
    check("rst_busy3", 32'(busy3), 0);
    check("rst_valid3", 32'(k_valid3), 0);

    // Basic fetch and full sweep
    reset = 1'b0;
    rd_cnt = 0;
    start_check("basic");
    sweep("sweep", KL);
    check("sweep_cmpl", 32'(address_read_complete), 1);
    check("sweep_valid", 32'(k_valid), 0);
    check("sweep_lastdata", k_data, 32'hc67178f2);
    repeat (5) tick();
    check("done_hold_cmpl", 32'(address_read_complete), 1);
    check("done_hold_busy", 32'(busy), 1);
    check("sweep_reads", 32'(rd_cnt), 64);
    enable = 1'b0;
    tick();
    expect_idle("done_abort");

    // next_req held every cycle: only HOLD cycles advance
    rd_cnt = 0;
    exp_idx = 0;
    cyc = 0;
    enable = 1'b1;
    next_req = 1'b1;
    while (!address_read_complete && cyc < 3000) begin
      tick();
      cyc++;
      if (k_valid) begin
        check("stray_kaddr", 32'(k_address), 32'(exp_idx));
        exp_idx++;
      end
    end
    next_req = 1'b0;
    check("stray_words", 32'(exp_idx), 64);
    check("stray_reads", 32'(rd_cnt), 64);
    check("stray_cmpl", 32'(address_read_complete), 1);
    enable = 1'b0;
    tick();

    // Abort two cycles after consuming word 16, then restart from 0
    start_check("pre_abort");
    sweep("abort_sweep", 17);
`ifndef K_FETCH_PREFETCH_EN
    check("abort_issue_rd", 32'(mem_read_en), 1);
    check("abort_issue_maddr", 32'(mem_address), 17);
`endif
    tick();
    enable = 1'b0;
    tick();
    expect_idle("abort");
    start_check("restart");

    // next_req every third cycle
    tick(); tick();
    for (int w = 0; w < 10; w++) begin
      check("cad_kaddr", 32'(k_address), 32'(w));
      next_req = 1'b1;
      for (int j = 1; j <= 3; j++) begin
        tick();
        next_req = 1'b0;
`ifdef K_FETCH_PREFETCH_EN
        check("cad_pf_valid", 32'(k_valid), 1);
        check("cad_pf_kaddr", 32'(k_address), 32'(w + 1));
`else
        if (j < 3) begin
          check("cad_bubble", 32'(k_valid), 0);
        end else begin
          check("cad_valid", 32'(k_valid), 1);
          check("cad_kdata", k_data, rom(w + 1));
        end
`endif
      end
    end

    // Reset mid-operation clears at the edge
    reset = 1'b1;
    tick();
    expect_idle("midrst");
    reset = 1'b0;
    enable = 1'b0;
    tick();

    // MEM_LATENCY=3 instance: data at every address, rise timing
    enable3 = 1'b1;
    exp_idx = 0;
    cyc = 0;
    rd_cyc = 0;
    prev_v = 1'b0;
    while (exp_idx < KL && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      next_req3 = 1'b0;
      if (mem_read_en3) rd_cyc = cyc;
      if (k_valid3 && !prev_v) begin
        check("lat3_kaddr", 32'(k_address3), 32'(exp_idx));
        check("lat3_kdata", k_data3, rom(exp_idx));
`ifndef K_FETCH_PREFETCH_EN
        check("lat3_rise", 32'(cyc - rd_cyc), 4);
`endif
        next_req3 = 1'b1;
        exp_idx++;
      end
      prev_v = k_valid3;
    end
    @(negedge clock);
    next_req3 = 1'b0;
    check("lat3_words", 32'(exp_idx), 64);
    check("lat3_cmpl", 32'(address_read_complete3), 1);
    check("lat3_lastdata", k_data3, 32'hc67178f2);
    enable3 = 1'b0;
    @(negedge clock);
    check("lat3_abort_busy", 32'(busy3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
